shiftout_sequencer: RTL and testbench

- Upstream feeder for the 16-bit serial shift-out driver.
- Holds a small bank of 16-bit words written by the host logic.
- Walks through the bank in order. For each word it presents the word to the driver, pulses the driver's start/reset input for one cycle, and waits for the driver's done indication.
- After an inter-word gap it moves to the next word, looping continuously while enabled. Typical use: scanned LED or 74HC595 chain refresh.

---
 rtl/shiftout_sequencer_pkg.sv | 24 ++
 rtl/shiftout_word_bank.sv | 26 ++
 rtl/shiftout_sequencer.sv | 166 ++++++++++++++++
 tb/tb_shiftout_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftout_sequencer_pkg.sv
// Shared definitions for the shift-out sequencer and the driver side:
// word width, FSM state encoding and the words-per-pass clamp.
package shiftout_sequencer_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } seq_state_e;

   // Number of WAIT_DONE cycles during which done edges are ignored, because
   // the driver only drops its previous done one cycle after the start pulse.
   localparam logic [1:0] DONE_HOLDOFF = 2'd2;

   // Words per pass: 0 or anything above the bank depth means "whole bank".
   function automatic logic [6:0] eff_count(input logic [6:0] cnt, input int depth);
      if (cnt == 7'd0 || int'(cnt) > depth) return 7'(depth);
      return cnt;
   endfunction

endpackage

// File: rtl/shiftout_word_bank.sv
// DEPTH x 16 register file: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module shiftout_word_bank
   import shiftout_sequencer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
)(
   input  logic              clk_in,
   input  logic              wr_en_in,
   input  logic [ADDR_W-1:0] wr_addr_in,
   input  logic [WORD_W-1:0] wr_data_in,
   input  logic [ADDR_W-1:0] rd_addr_in,
   output logic [WORD_W-1:0] rd_data_out
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   // Host write port; active in every sequencer state, including reset.
   always_ff @(posedge clk_in) begin
      if (wr_en_in) mem_q[wr_addr_in] <= wr_data_in;
   end

   assign rd_data_out = mem_q[rd_addr_in];

endmodule

// File: rtl/shiftout_sequencer.sv
// Shift-out sequencer: walks a word bank, handing each word to the serial
// driver with a one-cycle start pulse, waiting for done, then an idle gap.
// Optional watchdog in WAIT_DONE: define SHIFTOUT_SEQUENCER_TIMEOUT_EN.
//
// Driver handshake: start_out is a one-cycle pulse that coincides with the
// new bits_out; bits_out then stays stable until the next start. The driver
// answers by raising done_in (a level, high for one or more cycles); only a
// fresh rising edge seen at least DONE_HOLDOFF cycles after the start counts.
module shiftout_sequencer
   import shiftout_sequencer_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 3,
   parameter int GAP_CYCLES = 16
`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1024
`endif
)(
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              wr_en_in,
   input  logic [ADDR_W-1:0] wr_addr_in,
   input  logic [WORD_W-1:0] wr_data_in,
   input  logic              enable_in,
   input  logic [ADDR_W:0]   count_in,
   output logic [WORD_W-1:0] bits_out,
   output logic              start_out,
   input  logic              done_in,
   output logic [ADDR_W-1:0] index_out,
   output logic              pass_done_out,
   output logic              busy_out,
`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
   output logic              timeout_out,
`endif
   output logic [1:0]        state_dbg_out
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);
`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

   seq_state_e        state_q;
   logic [ADDR_W-1:0] index_q;
   logic [CNT_W-1:0]  count_q;
   logic [WORD_W-1:0] bits_q;
   logic              start_q;
   logic              pass_done_q;
   logic              done_prev_q;
   logic [1:0]        hold_q;
   logic [15:0]       gap_q;
`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
   logic [15:0]       tmo_q;
   logic              timeout_q;
`endif

   logic [WORD_W-1:0] rd_word;
   logic [CNT_W-1:0]  count_eff;
   logic              done_edge;
   logic              last_word;

   shiftout_word_bank #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_bank (
      .clk_in     (clk_in),
      .wr_en_in   (wr_en_in),
      .wr_addr_in (wr_addr_in),
      .wr_data_in (wr_data_in),
      .rd_addr_in (index_q),
      .rd_data_out(rd_word)
   );

   assign count_eff = CNT_W'(eff_count(7'(count_in), DEPTH));
   assign done_edge = done_in & ~done_prev_q & (hold_q == DONE_HOLDOFF);
   assign last_word = ({1'b0, index_q} == (count_q - CNT_W'(1)));

   // Previous done level for edge detection; follows done_in even in reset
   // so a level held across reset is never mistaken for an edge.
   always_ff @(posedge clk_in) begin
      done_prev_q <= done_in;
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q     <= ST_IDLE;
         index_q     <= '0;
         count_q     <= '0;
         bits_q      <= '0;
         start_q     <= 1'b0;
         pass_done_q <= 1'b0;
         hold_q      <= '0;
         gap_q       <= '0;
`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
         tmo_q       <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         start_q     <= 1'b0;
         pass_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (enable_in) begin
                  state_q <= ST_LOAD;
                  index_q <= '0;
                  count_q <= count_eff;
               end
            end
            ST_LOAD: begin
               // Bank read happens before any same-edge write lands: read-old.
               bits_q  <= rd_word;
               start_q <= 1'b1;
               hold_q  <= '0;
`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
               tmo_q   <= '0;
`endif
               state_q <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (hold_q != DONE_HOLDOFF) hold_q <= hold_q + 2'd1;
               if (done_edge) begin
                  gap_q   <= GAP_LOAD;
                  state_q <= ST_GAP;
               end
`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  timeout_q <= 1'b1;
                  gap_q     <= GAP_LOAD;
                  state_q   <= ST_GAP;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
`endif
            end
            ST_GAP: begin
               if (gap_q != 16'd0) begin
                  gap_q <= gap_q - 16'd1;
               end else begin
                  if (last_word) begin
                     pass_done_q <= 1'b1;
                     index_q     <= '0;
                     count_q     <= count_eff;
                  end else begin
                     index_q <= index_q + ADDR_W'(1);
                  end
                  state_q <= enable_in ? ST_LOAD : ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bits_out      = bits_q;
   assign start_out     = start_q;
   assign index_out     = index_q;
   assign pass_done_out = pass_done_q;
   assign busy_out      = (state_q != ST_IDLE);
   assign state_dbg_out = state_q;
`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
   assign timeout_out   = timeout_q;
`endif

endmodule

// File: tb/tb_shiftout_sequencer.sv
// Bench for shiftout_sequencer: driver model, start-pulse scoreboard,
// table of words-per-pass cases, randomized passes and corner sequences.
module tb_shiftout_sequencer;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int GAP    = 16;
   localparam int TMO    = 64;
   localparam int EW     = ADDR_W + 16;

   logic              clk = 1'b0;
   logic              reset_in;
   logic              wr_en_in;
   logic [ADDR_W-1:0] wr_addr_in;
   logic [15:0]       wr_data_in;
   logic              enable_in;
   logic [ADDR_W:0]   count_in;
   logic [15:0]       bits_out;
   logic              start_out;
   logic              done_in;
   logic [ADDR_W-1:0] index_out;
   logic              pass_done_out;
   logic              busy_out;
   logic [1:0]        state_dbg_out;
`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
   logic              timeout_out;
`endif

   shiftout_sequencer #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)
`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .clk_in(clk), .reset_in(reset_in), .wr_en_in(wr_en_in),
      .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
      .enable_in(enable_in), .count_in(count_in), .bits_out(bits_out),
      .start_out(start_out), .done_in(done_in), .index_out(index_out),
      .pass_done_out(pass_done_out), .busy_out(busy_out),
`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
      .timeout_out(timeout_out),
`endif
      .state_dbg_out(state_dbg_out)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- bookkeeping ----------------
   int vectors = 0;
   int miscompares = 0;
   logic [EW-1:0] exp_q[$];
   logic [15:0] model_bank [DEPTH];
   int  n_starts = 0;
   int  n_pass = 0;
   int  last_start_cyc = -1;
   bit  spacing_en = 0;
   int  exp_spacing = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- driver model ----------------
   bit drv_auto = 0;
   int drv_dly = 40;
   initial begin
      int cnt;
      int hold;
      cnt = 0;
      hold = 0;
      done_in = 1'b0;
      forever begin
         @(negedge clk);
         if (drv_auto) begin
            if (start_out) cnt = drv_dly;
            else if (cnt > 0) begin
               cnt--;
               if (cnt == 0) hold = 2;
            end
            done_in = (hold > 0);
            if (hold > 0) hold--;
         end else begin
            cnt = 0;
            hold = 0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial forever begin
      logic [EW-1:0] e;
      @(negedge clk);
      if (start_out) begin
         n_starts++;
         if (exp_q.size() == 0) begin
            check("unexpected_start", 32'(bits_out), 32'hDEAD_0000);
         end else begin
            e = exp_q.pop_front();
            check("start_word", 32'(bits_out), 32'(e[15:0]));
            check("start_index", 32'(index_out), 32'(e[EW-1:16]));
         end
         if (spacing_en && last_start_cyc >= 0)
            check("start_spacing", 32'(cyc - last_start_cyc), 32'(exp_spacing));
         last_start_cyc = cyc;
      end
      if (pass_done_out) begin
         n_pass++;
         check("pass_done_index", 32'(index_out), 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_write(input int addr, input logic [15:0] data);
      @(negedge clk);
      wr_en_in = 1'b1;
      wr_addr_in = ADDR_W'(addr);
      wr_data_in = data;
      model_bank[addr] = data;
      @(negedge clk);
      wr_en_in = 1'b0;
   endtask

   task automatic push_pass(input int words);
      for (int i = 0; i < words; i++) exp_q.push_back({ADDR_W'(i), model_bank[i]});
   endtask

   task automatic wait_starts(input int target, input int budget);
      for (int i = 0; i < budget && n_starts < target; i++) @(negedge clk);
      check("start_count", 32'(n_starts), 32'(target));
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy_out; i++) @(negedge clk);
      check("went_idle", 32'(busy_out), 32'd0);
   endtask

   task automatic wait_state(input logic [1:0] st, input int idx, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         if (state_dbg_out == st && int'(index_out) == idx) break;
      end
      check("reached_state", 32'(i < budget), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bits"}, 32'(bits_out), 32'd0);
      check({tag, "_start"}, 32'(start_out), 32'd0);
      check({tag, "_index"}, 32'(index_out), 32'd0);
      check({tag, "_pass_done"}, 32'(pass_done_out), 32'd0);
      check({tag, "_busy"}, 32'(busy_out), 32'd0);
      check({tag, "_state"}, 32'(state_dbg_out), 32'd0);
   endtask

   typedef struct {
      logic [ADDR_W:0] count;
      int              words;
   } vec_t;

   // ---------------- test sequence ----------------
   initial begin
      vec_t tbl [7];
      int base, bpass, eff, passes, c;
      tbl[0] = '{4'd0, 8};  tbl[1] = '{4'd1, 1};  tbl[2] = '{4'd3, 3};
      tbl[3] = '{4'd8, 8};  tbl[4] = '{4'd9, 8};  tbl[5] = '{4'd15, 8};
      tbl[6] = '{4'd2, 2};

      reset_in = 1'b1; enable_in = 1'b0; wr_en_in = 1'b0;
      wr_addr_in = '0; wr_data_in = '0; count_in = 4'd3;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_in = 1'b0;

      // Basic run: three words, two passes, constant spacing, latency 2.
      do_write(0, 16'hA5A5); do_write(1, 16'h0F0F); do_write(2, 16'h8001);
      drv_auto = 1; drv_dly = 40;
      exp_spacing = 40 + GAP + 3; spacing_en = 1; last_start_cyc = -1;
      push_pass(3); push_pass(3);
      base = n_starts; bpass = n_pass;
      @(negedge clk);
      enable_in = 1'b1;
      @(negedge clk);
      check("latency_no_start_yet", 32'(start_out), 32'd0);
      check("busy_after_enable", 32'(busy_out), 32'd1);
      @(negedge clk);
      check("latency_start_at_2", 32'(start_out), 32'd1);
      wait_starts(base + 6, 1000);
      enable_in = 1'b0;
      spacing_en = 0;
      wait_idle(200);
      check("basic_pass_count", 32'(n_pass - bpass), 32'd2);
      check("basic_bits_hold", 32'(bits_out), 32'h8001);
      check("basic_index_wrapped", 32'(index_out), 32'd0);
      repeat (20) @(negedge clk);
      check("no_start_after_stop", 32'(n_starts), 32'(base + 6));

      // Stale done level held from before enable must not count.
      drv_auto = 0; done_in = 1'b1; count_in = 4'd1;
      push_pass(1);
      base = n_starts;
      enable_in = 1'b1;
      wait_starts(base + 1, 20);
      enable_in = 1'b0;
      repeat (100) @(negedge clk);
      check("stale_done_waits", 32'(state_dbg_out), 32'd2);
      done_in = 1'b0;
      @(negedge clk);
      done_in = 1'b1;
      repeat (3) @(negedge clk);
      check("fresh_edge_to_gap", 32'(state_dbg_out), 32'd3);
      wait_idle(100);
      done_in = 1'b0;

      // Write bank[1] during its LOAD: old word now, new word next pass.
      drv_auto = 1; drv_dly = 10; count_in = 4'd3;
      push_pass(3);
      exp_q.push_back({ADDR_W'(0), 16'hA5A5});
      exp_q.push_back({ADDR_W'(1), 16'hFFFF});
      exp_q.push_back({ADDR_W'(2), 16'h8001});
      base = n_starts;
      enable_in = 1'b1;
      wait_state(2'd1, 1, 300);
      wr_en_in = 1'b1; wr_addr_in = 3'd1; wr_data_in = 16'hFFFF;
      @(negedge clk);
      wr_en_in = 1'b0;
      model_bank[1] = 16'hFFFF;
      wait_starts(base + 6, 1000);
      enable_in = 1'b0;
      wait_idle(200);

      // Reset while in GAP at index 2, then restart from index 0.
      push_pass(3);
      base = n_starts; bpass = n_pass;
      enable_in = 1'b1;
      wait_state(2'd3, 2, 500);
      reset_in = 1'b1;
      @(negedge clk);
      check("gap_reset_bits", 32'(bits_out), 32'd0);
      check("gap_reset_index", 32'(index_out), 32'd0);
      check("gap_reset_busy", 32'(busy_out), 32'd0);
      check("gap_reset_state", 32'(state_dbg_out), 32'd0);
      push_pass(1);
      reset_in = 1'b0;
      wait_starts(base + 4, 50);
      enable_in = 1'b0;
      wait_idle(200);
      check("gap_reset_no_pass_done", 32'(n_pass - bpass), 32'd0);

      // Words-per-pass table, including the 0 / above-DEPTH clamp.
      for (int i = 0; i < DEPTH; i++) do_write(i, 16'(32'h1111 * (i + 1)));
      drv_dly = 4;
      for (int t = 0; t < 7; t++) begin
         count_in = tbl[t].count;
         push_pass(tbl[t].words);
         base = n_starts; bpass = n_pass;
         enable_in = 1'b1;
         wait_starts(base + tbl[t].words, 400);
         enable_in = 1'b0;
         wait_idle(100);
         check("table_pass_done", 32'(n_pass - bpass), 32'd1);
         check("table_queue_empty", 32'(exp_q.size()), 32'd0);
      end

      // Randomized passes against the reference rule.
      for (int r = 0; r < 6; r++) begin
         for (int w = 0; w < 4; w++) do_write($urandom_range(0, DEPTH - 1), 16'($urandom));
         c = $urandom_range(0, 15);
         eff = (c == 0 || c > DEPTH) ? DEPTH : c;
         passes = $urandom_range(1, 2);
         drv_dly = $urandom_range(3, 30);
         count_in = 4'(c);
         for (int p = 0; p < passes; p++) push_pass(eff);
         base = n_starts; bpass = n_pass;
         enable_in = 1'b1;
         wait_starts(base + eff * passes, 3000);
         enable_in = 1'b0;
         wait_idle(200);
         check("rand_pass_done", 32'(n_pass - bpass), 32'(passes));
         check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
      end

`ifdef SHIFTOUT_SEQUENCER_TIMEOUT_EN
      // Watchdog: done never arrives.
      begin
         int t0, t1;
         drv_auto = 0; done_in = 1'b0; count_in = 4'd1;
         check("timeout_initially_clear", 32'(timeout_out), 32'd0);
         push_pass(1); push_pass(1);
         base = n_starts;
         enable_in = 1'b1;
         wait_starts(base + 1, 20);
         t0 = last_start_cyc;
         t1 = -1;
         for (int i = 0; i < 200; i++) begin
            if (timeout_out) begin
               t1 = cyc;
               break;
            end
            @(negedge clk);
         end
         check("timeout_delay", 32'(t1 - t0), 32'(TMO));
         wait_starts(base + 2, 200);
         enable_in = 1'b0;
         wait_idle(200);
         check("timeout_sticky", 32'(timeout_out), 32'd1);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute safety net against a hung run.
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "global timeout");
   end

endmodule
